mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised successor to the pipeline MEM stage; sits between the EX/MEM register and the memory controller.
- Drives an explicit request/grant/response handshake with an FSM instead of level-held enables.
- Adds misalignment detection, flush handling with in-flight load drain, a global ready pause, and a registered one-cycle result for loads and stores.
- Non-memory instructions pass through combinationally to WB and forwarding.

Parameters:
XLEN, 32, register/data width (sign-extension targets XLEN)
ADDR_W, 32, byte address width
REG_ADDR_W, 5, register index width

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global ready; low freezes FSM and all registers
flush_i  in  1  pipeline flush (branch mispredict)
valid_i  in  1  EX/MEM holds a valid instruction
mem_en_i  in  1  instruction is LOAD/STORE
wr_i  in  1  1=store, 0=load
funct3_i  in  3  RISC-V width/sign field
addr_i  in  ADDR_W  effective byte address
store_data_i  in  XLEN  rs2 value
rd_addr_i  in  REG_ADDR_W  destination register
rd_we_i  in  1  destination write enable
rd_data_i  in  XLEN  ALU result
next_pc_i  in  ADDR_W  pass-through PC
mreq_o  out  1  request valid to memory controller
mwr_o  out  1  request is a write
maddr_o  out  ADDR_W  request byte address
msize_o  out  2  0=byte, 1=half, 2=word
mwdata_o  out  XLEN  store data, right-aligned
mgnt_i  in  1  controller accepts the request this cycle
mrvalid_i  in  1  load data valid
mrdata_i  in  XLEN  raw load data, right-aligned
stall_req_o  out  1  stall upstream stages
rd_data_o  out  XLEN  writeback/forward data
rd_addr_o  out  REG_ADDR_W  writeback register
rd_we_o  out  1  writeback enable
next_pc_o  out  ADDR_W  pass-through
misalign_o  out  1  one-cycle misaligned-access exception pulse

Behaviour:
- Reset (rst_in=1 at clk_in edge):
  - state=IDLE; mreq_o=0; misalign_o=0; internal load-data register=0.
  - rd_we_o=0 and stall_req_o=0 while reset is asserted.
  - Reset mid-transaction abandons it; the controller is reset by the same signal.
- States:
  - IDLE: accept new op.
  - REQ: mreq_o=1, awaiting mgnt_i.
  - WAIT: load issued, awaiting mrvalid_i.
  - DONE: result presented for one cycle.
  - DRAIN: flushed load awaiting mrvalid_i.
- IDLE, op = valid_i & mem_en_i & ~flush_i:
  - Misaligned: half with addr[0]≠0, or word with addr[1:0]≠0.
    - misalign_o=1 for one cycle; no request; rd_we_o=0; stall_req_o=0; stay IDLE.
  - Otherwise go to REQ; stall_req_o=1 combinationally in the same cycle.
- REQ:
  - maddr/msize/mwr/mwdata are captured from the inputs on IDLE→REQ and stay stable until grant.
  - mgnt_i=1 with store → DONE. Stores are posted; completion is the grant.
  - mgnt_i=1 with load → WAIT.
  - flush_i=1 before grant → IDLE; mreq_o drops the next cycle; nothing issued.
  - flush_i=1 in the same cycle as mgnt_i: the op is issued. A store completes. A load goes to DRAIN.
- WAIT:
  - mrvalid_i=1 → capture mrdata_i → DONE.
  - flush_i=1 → DRAIN. mrvalid_i in that same cycle is discarded and the FSM goes to IDLE.
  - mrvalid_i is never earlier than the cycle after grant.
- DRAIN: mrvalid_i → IDLE; no writeback; stall_req_o=0.
- DONE:
  - stall_req_o=0; rd_addr_o/rd_we_o come from the inputs.
  - Store: rd_data_o=0.
  - Load: rd_data_o = extended captured data:
    - LB/LH sign-extend bit 7/15 to XLEN.
    - LBU/LHU zero-extend.
    - LW takes the low 32 bits; for XLEN>32 it sign-extends.
  - Next state IDLE. The EX/MEM register advances on this edge, so a back-to-back mem op starts one cycle later.
- stall_req_o = op_pending & (state≠DONE), where op_pending = valid_i & mem_en_i & ~misaligned in IDLE, and 1 in REQ/WAIT.
- Non-memory or !valid_i: rd_data_o=rd_data_i, rd_we_o=rd_we_i&valid_i, fully combinational.
- rdy_in=0: state and captured registers hold; mreq_o holds its value.
- funct3 outside the defined loads/stores: treated as a word access, and loads return 0.

Decomposition:
- Shared package holds:
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW.
  - msize encodings.
  - FSM state enum.
  - Read/Write and Enable/Disable constants.
- One sub-module, load_extend (funct3, raw data → XLEN result), purely combinational and reused by future caches.

Test Plan:
- LB at 0x1001, mgnt_i after 2 cycles, mrvalid_i data 0x80 after 3 more cycles → rd_data_o=0xFFFFFF80 in DONE, rd_we_o=1, stall_req_o high for exactly 6 cycles.
- SW at 0x2000, data 0xDEADBEEF, immediate grant → mreq_o 1 cycle, msize_o=2, DONE next cycle, rd_data_o=0.
- LW at 0x1002 → misalign_o=1 for 1 cycle, mreq_o stays 0, rd_we_o=0, no stall.
- LHU issued, flush_i in WAIT, mrvalid_i 4 cycles later with 0xFFFF → no writeback, FSM back to IDLE after mrvalid_i, next op accepted.
- Load in REQ, rdy_in=0 for 3 cycles with mgnt_i=0 → mreq_o and maddr_o stable, state unchanged; completes normally once rdy_in=1.
- ADD result 0x55 with mem_en_i=0 → rd_data_o=0x55 in the same cycle, stall_req_o=0; rst_in during WAIT → IDLE, mreq_o=0 next cycle.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_pkg
//  Description : Shared constants, FSM encoding and access-size helpers for
//                the memory access unit and its load extender.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;
    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;

    localparam logic [1:0] c_MSIZE_BYTE = 2'd0;
    localparam logic [1:0] c_MSIZE_HALF = 2'd1;
    localparam logic [1:0] c_MSIZE_WORD = 2'd2;

    localparam logic c_READ    = 1'b0;
    localparam logic c_WRITE   = 1'b1;
    localparam logic c_DISABLE = 1'b0;
    localparam logic c_ENABLE  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } mau_state_e;

    // Undefined funct3 encodings fall back to a word access.
    function automatic logic [1:0] access_size(input logic wr, input logic [2:0] funct3);
        logic [1:0] size;
        size = c_MSIZE_WORD;
        if (funct3 == c_F3_SB || (wr == c_READ && funct3 == c_F3_LBU)) begin
            size = c_MSIZE_BYTE;
        end else if (funct3 == c_F3_SH || (wr == c_READ && funct3 == c_F3_LHU)) begin
            size = c_MSIZE_HALF;
        end
        return size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            c_MSIZE_HALF: mis = addr_lo[0];
            c_MSIZE_WORD: mis = |addr_lo;
            default:      mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_extend.sv
`default_nettype none
// ============================================================================
//  Module      : load_extend
//  Description : Combinational RISC-V load data extension (LB/LH/LW/LBU/LHU).
//  Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_raw,
    output logic [XLEN-1:0] o_result
);

    logic [XLEN-1:0] w_word;

    generate
        if (XLEN > 32) begin : g_word_sext
            assign w_word = {{(XLEN-32){i_raw[31]}}, i_raw[31:0]};
        end else begin : g_word_native
            assign w_word = i_raw;
        end
    endgenerate

    always_comb begin
        o_result = '0;
        case (i_funct3)
            c_F3_LB:  o_result = {{(XLEN-8){i_raw[7]}}, i_raw[7:0]};
            c_F3_LH:  o_result = {{(XLEN-16){i_raw[15]}}, i_raw[15:0]};
            c_F3_LW:  o_result = w_word;
            c_F3_LBU: o_result = {{(XLEN-8){1'b0}}, i_raw[7:0]};
            c_F3_LHU: o_result = {{(XLEN-16){1'b0}}, i_raw[15:0]};
            default:  o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : MEM stage with request/grant/response handshake FSM,
//                misalignment detection, flush drain and global ready pause.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic                  mem_en_i,
    input  logic                  wr_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [XLEN-1:0]       store_data_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  rd_we_i,
    input  logic [XLEN-1:0]       rd_data_i,
    input  logic [ADDR_W-1:0]     next_pc_i,
    output logic                  mreq_o,
    output logic                  mwr_o,
    output logic [ADDR_W-1:0]     maddr_o,
    output logic [1:0]            msize_o,
    output logic [XLEN-1:0]       mwdata_o,
    input  logic                  mgnt_i,
    input  logic                  mrvalid_i,
    input  logic [XLEN-1:0]       mrdata_i,
    output logic                  stall_req_o,
    output logic [XLEN-1:0]       rd_data_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  rd_we_o,
    output logic [ADDR_W-1:0]     next_pc_o,
    output logic                  misalign_o
);

    mau_state_e        state_q,    state_d;
    logic [ADDR_W-1:0] maddr_q,    maddr_d;
    logic [1:0]        msize_q,    msize_d;
    logic              mwr_q,      mwr_d;
    logic [XLEN-1:0]   mwdata_q,   mwdata_d;
    logic [2:0]        funct3_q,   funct3_d;
    logic [XLEN-1:0]   ldata_q,    ldata_d;
    logic              misalign_q, misalign_d;

    logic [1:0]        w_size;
    logic              w_misaligned;
    logic              w_mem_op;
    logic              w_op_start;
    logic              w_pending;
    logic [XLEN-1:0]   w_load_result;

    assign w_size       = access_size(wr_i, funct3_i);
    assign w_misaligned = is_misaligned(w_size, addr_i[1:0]);
    assign w_mem_op     = valid_i & mem_en_i;
    assign w_op_start   = w_mem_op & ~flush_i;

    load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .i_funct3 (funct3_q),
        .i_raw    (ldata_q),
        .o_result (w_load_result)
    );

    always_comb begin
        state_d    = state_q;
        maddr_d    = maddr_q;
        msize_d    = msize_q;
        mwr_d      = mwr_q;
        mwdata_d   = mwdata_q;
        funct3_d   = funct3_q;
        ldata_d    = ldata_q;
        misalign_d = c_DISABLE;
        case (state_q)
            ST_IDLE: begin
                if (w_op_start) begin
                    if (w_misaligned) begin
                        misalign_d = c_ENABLE;
                    end else begin
                        state_d  = ST_REQ;
                        maddr_d  = addr_i;
                        msize_d  = w_size;
                        mwr_d    = wr_i;
                        mwdata_d = store_data_i;
                        funct3_d = funct3_i;
                    end
                end
            end
            ST_REQ: begin
                // A grant wins over a same-cycle flush: the op is already issued.
                if (mgnt_i) begin
                    if (mwr_q == c_WRITE) begin
                        state_d = ST_DONE;
                    end else if (flush_i) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (flush_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    state_d = mrvalid_i ? ST_IDLE : ST_DRAIN;
                end else if (mrvalid_i) begin
                    ldata_d = mrdata_i;
                    state_d = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (mrvalid_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            maddr_q    <= '0;
            msize_q    <= c_MSIZE_BYTE;
            mwr_q      <= c_READ;
            mwdata_q   <= '0;
            funct3_q   <= '0;
            ldata_q    <= '0;
            misalign_q <= c_DISABLE;
        end else if (rdy_in) begin
            state_q    <= state_d;
            maddr_q    <= maddr_d;
            msize_q    <= msize_d;
            mwr_q      <= mwr_d;
            mwdata_q   <= mwdata_d;
            funct3_q   <= funct3_d;
            ldata_q    <= ldata_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        mreq_o     = (state_q == ST_REQ);
        mwr_o      = mwr_q;
        maddr_o    = maddr_q;
        msize_o    = msize_q;
        mwdata_o   = mwdata_q;
        misalign_o = misalign_q;
        next_pc_o  = next_pc_i;
        rd_addr_o  = rd_addr_i;

        case (state_q)
            ST_IDLE:         w_pending = w_mem_op & ~w_misaligned;
            ST_REQ, ST_WAIT: w_pending = 1'b1;
            default:         w_pending = 1'b0;
        endcase
        stall_req_o = w_pending & ~rst_in;

        // EX/MEM still holds the op in DONE, so rd_addr/rd_we come straight through.
        if (state_q == ST_DONE) begin
            rd_data_o = (mwr_q == c_WRITE) ? '0 : w_load_result;
            rd_we_o   = rd_we_i;
        end else if (w_mem_op) begin
            rd_data_o = rd_data_i;
            rd_we_o   = c_DISABLE;
        end else begin
            rd_data_o = rd_data_i;
            rd_we_o   = rd_we_i & valid_i;
        end
        if (rst_in) begin
            rd_we_o = c_DISABLE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit with a behavioural
//                memory-controller model and load/size reference functions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int XLEN = 32;
    localparam int ADDR_W = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] F_LB = 3'd0, F_LH = 3'd1, F_LW = 3'd2, F_LBU = 3'd4, F_LHU = 3'd5;

    logic                  clk_in = 1'b0;
    logic                  rst_in, rdy_in, flush_i, valid_i, mem_en_i, wr_i;
    logic [2:0]            funct3_i;
    logic [ADDR_W-1:0]     addr_i, next_pc_i;
    logic [XLEN-1:0]       store_data_i, rd_data_i, mrdata_i;
    logic [REG_ADDR_W-1:0] rd_addr_i;
    logic                  rd_we_i, mgnt_i, mrvalid_i;
    logic                  mreq_o, mwr_o, stall_req_o, rd_we_o, misalign_o;
    logic [ADDR_W-1:0]     maddr_o, next_pc_o;
    logic [1:0]            msize_o;
    logic [XLEN-1:0]       mwdata_o, rd_data_o;
    logic [REG_ADDR_W-1:0] rd_addr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    mem_access_unit #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .REG_ADDR_W(REG_ADDR_W)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_i(flush_i),
        .valid_i(valid_i), .mem_en_i(mem_en_i), .wr_i(wr_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .store_data_i(store_data_i), .rd_addr_i(rd_addr_i),
        .rd_we_i(rd_we_i), .rd_data_i(rd_data_i), .next_pc_i(next_pc_i),
        .mreq_o(mreq_o), .mwr_o(mwr_o), .maddr_o(maddr_o), .msize_o(msize_o),
        .mwdata_o(mwdata_o), .mgnt_i(mgnt_i), .mrvalid_i(mrvalid_i), .mrdata_i(mrdata_i),
        .stall_req_o(stall_req_o), .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o),
        .rd_we_o(rd_we_o), .next_pc_o(next_pc_o), .misalign_o(misalign_o)
    );

    // Reference rules: access size in bytes as a power of two.
    function automatic int model_size(input logic wr, input logic [2:0] f3);
        if (f3 == 3'd0 || (!wr && f3 == 3'd4)) return 0;
        if (f3 == 3'd1 || (!wr && f3 == 3'd5)) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] raw);
        longint v;
        case (f3)
            3'd0: begin v = raw % 256;   if (v >= 128)   v -= 256;   end
            3'd1: begin v = raw % 65536; if (v >= 32768) v -= 65536; end
            3'd2: v = raw;
            3'd4: v = raw % 256;
            3'd5: v = raw % 65536;
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    task automatic idle_cycle();
        valid_i = 1'b0; mem_en_i = 1'b0; flush_i = 1'b0; mgnt_i = 1'b0; mrvalid_i = 1'b0;
        @(posedge clk_in); #1;
    endtask

    task automatic start_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sdata);
        valid_i = 1'b1; mem_en_i = 1'b1; wr_i = wr; funct3_i = f3; addr_i = addr;
        store_data_i = sdata; rd_addr_i = 5'($urandom); rd_we_i = 1'b1;
        rd_data_i = $urandom; next_pc_i = $urandom; flush_i = 1'b0;
    endtask

    // Full transaction with a controller that grants on the gdly-th request
    // cycle and returns load data on the rdly-th cycle after the grant.
    task automatic run_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata,
                          input int gdly, input int rdly, input string tag);
        int stall_cnt = 0, req_cnt = 0, wcnt = 0;
        bit granted = 0, done = 0;
        logic [31:0] exp;
        logic [4:0] rda;
        start_op(wr, f3, addr, sdata);
        rda = rd_addr_i;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk_in);
            mgnt_i = 1'b0; mrvalid_i = 1'b0;
            if (!stall_req_o) begin
                done = 1;
                exp = wr ? 32'h0 : model_load(f3, rdata);
                checks++;
                if (rd_data_o !== exp) begin
                    errors++; $display("FAIL %s rd_data got=%h exp=%h", tag, rd_data_o, exp);
                end
                checks++;
                if (rd_we_o !== 1'b1 || rd_addr_o !== rda) begin
                    errors++; $display("FAIL %s writeback got we=%b rd=%0d exp we=1 rd=%0d", tag, rd_we_o, rd_addr_o, rda);
                end
                checks++;
                if (stall_cnt != 1 + gdly + (wr ? 0 : rdly) || req_cnt != gdly) begin
                    errors++;
                    $display("FAIL %s timing got stall=%0d req=%0d exp stall=%0d req=%0d",
                             tag, stall_cnt, req_cnt, 1 + gdly + (wr ? 0 : rdly), gdly);
                end
            end else begin
                stall_cnt++;
                checks++;
                if (rd_we_o !== 1'b0) begin
                    errors++; $display("FAIL %s stall_we got=%b exp=0", tag, rd_we_o);
                end
                if (granted && !wr) begin
                    wcnt++;
                    mrdata_i = (wcnt == rdly) ? rdata : $urandom;
                    mrvalid_i = (wcnt == rdly);
                end
                if (mreq_o) begin
                    req_cnt++;
                    checks++;
                    if (maddr_o !== addr || msize_o !== 2'(model_size(wr, f3)) || mwr_o !== wr ||
                        (wr && mwdata_o !== sdata)) begin
                        errors++;
                        $display("FAIL %s request got a=%h s=%0d w=%b d=%h exp a=%h s=%0d w=%b d=%h", tag,
                                 maddr_o, msize_o, mwr_o, mwdata_o, addr, model_size(wr, f3), wr, sdata);
                    end
                    if (req_cnt == gdly) begin mgnt_i = 1'b1; granted = 1; end
                end
            end
        end
        if (!done) begin
            errors++; $display("FAIL %s timeout got=no_done exp=done", tag);
        end
        @(posedge clk_in); #1;
        mgnt_i = 1'b0; mrvalid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        start_op(1'b0, F_LW, 32'h0, 32'h0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if (mreq_o !== 1'b0 || misalign_o !== 1'b0 || stall_req_o !== 1'b0 || rd_we_o !== 1'b0) begin
            errors++; $display("FAIL reset got req=%b mis=%b stall=%b we=%b exp all 0", mreq_o, misalign_o, stall_req_o, rd_we_o);
        end
        @(posedge clk_in); #1;
        rst_in = 1'b0; valid_i = 1'b0; mem_en_i = 1'b0;
        @(negedge clk_in);
        checks++;
        if (mreq_o !== 1'b0 || stall_req_o !== 1'b0) begin
            errors++; $display("FAIL reset_release got req=%b stall=%b exp 0 0", mreq_o, stall_req_o);
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_directed_ops();
        run_op(1'b0, F_LB, 32'h1001, 32'h0, 32'h0000_0080, 2, 3, "lb_sext");
        idle_cycle();
        run_op(1'b1, F_LW, 32'h2000, 32'hDEAD_BEEF, 32'h0, 1, 0, "sw");
        idle_cycle();
        run_op(1'b0, F_LHU, 32'h10, 32'h0, 32'hABCD_8001, 1, 1, "lhu");
        run_op(1'b0, 3'd7, 32'h20, 32'h0, 32'h1234_5678, 1, 2, "bad_f3_load");
        idle_cycle();
    endtask

    task automatic test_misalign();
        logic        t_wr[5]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  t_f3[5]   = '{F_LW, F_LH, F_LW, F_LH, F_LHU};
        logic [31:0] t_addr[5] = '{32'h1002, 32'h1001, 32'h3003, 32'h5, 32'h7};
        for (int i = 0; i < 5; i++) begin
            start_op(t_wr[i], t_f3[i], t_addr[i], 32'h0);
            @(negedge clk_in);
            checks++;
            if (stall_req_o !== 1'b0 || mreq_o !== 1'b0 || rd_we_o !== 1'b0) begin
                errors++; $display("FAIL misalign_detect[%0d] got stall=%b req=%b we=%b exp 0 0 0", i, stall_req_o, mreq_o, rd_we_o);
            end
            @(posedge clk_in); #1;
            valid_i = 1'b0; mem_en_i = 1'b0;
            @(negedge clk_in);
            checks++;
            if (misalign_o !== 1'b1 || mreq_o !== 1'b0) begin
                errors++; $display("FAIL misalign_pulse[%0d] got mis=%b req=%b exp 1 0", i, misalign_o, mreq_o);
            end
            @(posedge clk_in); #1;
            @(negedge clk_in);
            checks++;
            if (misalign_o !== 1'b0 || mreq_o !== 1'b0) begin
                errors++; $display("FAIL misalign_clear[%0d] got mis=%b req=%b exp 0 0", i, misalign_o, mreq_o);
            end
            @(posedge clk_in); #1;
        end
    endtask

    task automatic test_flush_drain();
        // Flush while waiting for data: the late response must not write back.
        start_op(1'b0, F_LHU, 32'h1002, 32'h0);
        @(posedge clk_in); #1;
        @(negedge clk_in); mgnt_i = 1'b1;
        @(posedge clk_in); #1; mgnt_i = 1'b0;
        @(negedge clk_in); flush_i = 1'b1;
        @(posedge clk_in); #1;
        flush_i = 1'b0; valid_i = 1'b0; mem_en_i = 1'b0; rd_we_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_in);
            checks++;
            if (rd_we_o !== 1'b0 || stall_req_o !== 1'b0 || mreq_o !== 1'b0) begin
                errors++; $display("FAIL drain[%0d] got we=%b stall=%b req=%b exp 0 0 0", i, rd_we_o, stall_req_o, mreq_o);
            end
            if (i == 4) begin mrvalid_i = 1'b1; mrdata_i = 32'hFFFF; end
            @(posedge clk_in); #1; mrvalid_i = 1'b0;
        end
        @(negedge clk_in);
        checks++;
        if (rd_we_o !== 1'b0) begin
            errors++; $display("FAIL drain_end got we=%b exp=0", rd_we_o);
        end
        @(posedge clk_in); #1;
        run_op(1'b0, F_LW, 32'h40, 32'h0, $urandom, 1, 2, "after_drain");

        // Flush before grant: request withdrawn.
        start_op(1'b0, F_LW, 32'h80, 32'h0);
        @(posedge clk_in); #1;
        @(negedge clk_in); flush_i = 1'b1;
        @(posedge clk_in); #1;
        flush_i = 1'b0; valid_i = 1'b0; mem_en_i = 1'b0;
        @(negedge clk_in);
        checks++;
        if (mreq_o !== 1'b0 || stall_req_o !== 1'b0) begin
            errors++; $display("FAIL flush_req got req=%b stall=%b exp 0 0", mreq_o, stall_req_o);
        end
        @(posedge clk_in); #1;
        run_op(1'b1, F_LH, 32'h82, 32'h0000_BEEF, 32'h0, 2, 0, "after_flush_req");

        // Flush and response together in WAIT: straight back to IDLE.
        start_op(1'b0, F_LB, 32'h91, 32'h0);
        @(posedge clk_in); #1;
        @(negedge clk_in); mgnt_i = 1'b1;
        @(posedge clk_in); #1; mgnt_i = 1'b0;
        @(negedge clk_in); flush_i = 1'b1; mrvalid_i = 1'b1; mrdata_i = 32'h7F;
        @(posedge clk_in); #1;
        flush_i = 1'b0; mrvalid_i = 1'b0; valid_i = 1'b0; mem_en_i = 1'b0;
        @(negedge clk_in);
        checks++;
        if (rd_we_o !== 1'b0) begin
            errors++; $display("FAIL flush_rvalid got we=%b exp=0", rd_we_o);
        end
        @(posedge clk_in); #1;
        run_op(1'b0, F_LH, 32'hA0, 32'h0, 32'h0000_8000, 1, 1, "after_flush_rvalid");
        idle_cycle();
    endtask

    task automatic test_rdy_pause();
        logic [31:0] rdata;
        rdata = $urandom;
        start_op(1'b0, F_LW, 32'h3000, 32'h0);
        @(posedge clk_in); #1;
        @(negedge clk_in); rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in); #1;
            addr_i = $urandom;
            @(negedge clk_in);
            checks++;
            if (mreq_o !== 1'b1 || maddr_o !== 32'h3000 || stall_req_o !== 1'b1) begin
                errors++; $display("FAIL rdy_pause[%0d] got req=%b addr=%h stall=%b exp 1 00003000 1", i, mreq_o, maddr_o, stall_req_o);
            end
        end
        rdy_in = 1'b1; mgnt_i = 1'b1;
        @(posedge clk_in); #1; mgnt_i = 1'b0;
        @(negedge clk_in); mrvalid_i = 1'b1; mrdata_i = rdata;
        @(posedge clk_in); #1; mrvalid_i = 1'b0;
        @(negedge clk_in);
        checks++;
        if (rd_data_o !== rdata || rd_we_o !== 1'b1 || stall_req_o !== 1'b0) begin
            errors++; $display("FAIL rdy_resume got d=%h we=%b stall=%b exp d=%h we=1 stall=0", rd_data_o, rd_we_o, stall_req_o, rdata);
        end
        @(posedge clk_in); #1;
        idle_cycle();
    endtask

    task automatic test_passthrough();
        logic v, we;
        logic [31:0] d, pc;
        for (int i = 0; i < 8; i++) begin
            v  = (i == 0) ? 1'b1 : 1'($urandom);
            we = (i == 0) ? 1'b1 : 1'($urandom);
            d  = (i == 0) ? 32'h55 : $urandom;
            pc = $urandom;
            valid_i = v; mem_en_i = 1'b0; rd_we_i = we; rd_data_i = d; next_pc_i = pc;
            wr_i = 1'($urandom); addr_i = $urandom;
            #1;
            checks++;
            if (rd_data_o !== d || rd_we_o !== (v & we) || stall_req_o !== 1'b0 ||
                next_pc_o !== pc || mreq_o !== 1'b0) begin
                errors++;
                $display("FAIL passthru[%0d] got d=%h we=%b stall=%b pc=%h exp d=%h we=%b stall=0 pc=%h",
                         i, rd_data_o, rd_we_o, stall_req_o, next_pc_o, d, v & we, pc);
            end
            @(posedge clk_in); #1;
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        start_op(1'b0, F_LW, 32'h500, 32'h0);
        @(posedge clk_in); #1;
        @(negedge clk_in); mgnt_i = 1'b1;
        @(posedge clk_in); #1; mgnt_i = 1'b0;
        @(negedge clk_in); rst_in = 1'b1;
        #1;
        checks++;
        if (stall_req_o !== 1'b0 || rd_we_o !== 1'b0) begin
            errors++; $display("FAIL reset_comb got stall=%b we=%b exp 0 0", stall_req_o, rd_we_o);
        end
        @(posedge clk_in); #1;
        rst_in = 1'b0; valid_i = 1'b0; mem_en_i = 1'b0;
        @(negedge clk_in);
        checks++;
        if (mreq_o !== 1'b0 || stall_req_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid got req=%b stall=%b exp 0 0", mreq_o, stall_req_o);
        end
        @(posedge clk_in); #1;
        run_op(1'b0, F_LBU, 32'h503, 32'h0, 32'h0000_00F0, 1, 1, "after_reset");
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, F_LW, 32'h600, 32'h0, $urandom, 1, 1, "b2b_lw");
        run_op(1'b1, F_LB, 32'h603, 32'h0000_00A5, 32'h0, 2, 0, "b2b_sb");
        run_op(1'b0, F_LH, 32'h606, 32'h0, 32'h0000_7FFF, 3, 2, "b2b_lh");
        idle_cycle();
    endtask

    task automatic test_random();
        logic wr;
        logic [2:0] f3;
        logic [31:0] addr;
        int size;
        for (int i = 0; i < 30; i++) begin
            wr = 1'($urandom);
            f3 = 3'($urandom);
            size = model_size(wr, f3);
            addr = $urandom & ~((32'd1 << size) - 32'd1);
            run_op(wr, f3, addr, $urandom, $urandom, 1 + $urandom_range(0, 3),
                   1 + $urandom_range(0, 3), "random");
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush_i = 1'b0; valid_i = 1'b0; mem_en_i = 1'b0;
        wr_i = 1'b0; funct3_i = 3'd0; addr_i = '0; store_data_i = '0; rd_addr_i = '0;
        rd_we_i = 1'b0; rd_data_i = '0; next_pc_i = '0; mgnt_i = 1'b0; mrvalid_i = 1'b0;
        mrdata_i = '0;
        test_reset();
        test_directed_ops();
        test_misalign();
        test_flush_drain();
        test_rdy_pause();
        test_passthrough();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
